pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-PC interface: redirect/stall/RAS controls into pc_gen, fetch PC back out.
// The slave modport is the PC generator; the master modport is the pipeline control side.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_vec_i;
    logic            flush_i;
    logic [XLEN-1:0] flush_pc_i;
    logic            br_sel_i;
    logic [XLEN-1:0] pc_bru_i;
    logic            call_i;
    logic            ret_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_four_o;
    logic            pc_valid_o;

    modport master (
        output stall_i, trap_i, trap_vec_i, flush_i, flush_pc_i,
               br_sel_i, pc_bru_i, call_i, ret_i,
        input  pc_o, pc_four_o, pc_valid_o
    );

    modport slave (
        input  stall_i, trap_i, trap_vec_i, flush_i, flush_pc_i,
               br_sel_i, pc_bru_i, call_i, ret_i,
        output pc_o, pc_four_o, pc_valid_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with BOOT/RUN sequencing and an optional
// circular return-address stack, built only when PC_GEN_RAS_EN is defined.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input logic     clk_i,
    input logic     rst_ni,
    pc_gen_if.slave bus
);
    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_four;
    logic            ras_hit;
    logic [XLEN-1:0] ras_top;

    assign pc_four        = pc_q + XLEN'(4);
    assign bus.pc_o       = pc_q;
    assign bus.pc_four_o  = pc_four;
    assign bus.pc_valid_o = (state_q == RUN);

`ifdef PC_GEN_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, top_idx;
    logic [PTR_W:0]   cnt_q;
    logic             ras_act, ras_empty, do_push, do_pop, do_swap;

    // ptr_q is the next free slot; once full it points at the oldest entry,
    // so a further push overwrites it in place.
    assign top_idx   = ptr_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_act   = (state_q == RUN) && !bus.stall_i && !bus.flush_i && !bus.trap_i;
    assign do_swap   = ras_act && bus.call_i && bus.ret_i && !ras_empty;
    assign do_push   = ras_act && bus.call_i && !do_swap;
    assign do_pop    = ras_act && bus.ret_i && !bus.call_i && !ras_empty;
    assign ras_hit   = bus.ret_i && !ras_empty;
    assign ras_top   = ras_q[top_idx];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            ras_q[ptr_q] <= pc_four;
        end else if (do_swap) begin
            ras_q[top_idx] <= pc_four;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (bus.flush_i || bus.trap_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (do_push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (cnt_q != (PTR_W+1)'(RAS_DEPTH)) begin
                cnt_q <= cnt_q + (PTR_W+1)'(1);
            end
        end else if (do_pop) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - (PTR_W+1)'(1);
        end
    end
`else
    assign ras_hit = 1'b0;
    assign ras_top = '0;
`endif

    always_comb begin
        state_d = RUN;
        pc_d    = pc_q;
        if (state_q == BOOT) begin
            pc_d = RESET_VECTOR;
        end else if (bus.trap_i) begin
            pc_d = bus.trap_vec_i;
        end else if (bus.flush_i) begin
            pc_d = bus.flush_pc_i;
        end else if (bus.stall_i) begin
            pc_d = pc_q;
        end else if (bus.br_sel_i) begin
            pc_d = bus.pc_bru_i;
        end else if (ras_hit) begin
            pc_d = ras_top;
        end else begin
            pc_d = pc_four;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= {pc_d[XLEN-1:2], 2'b00};
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen; RAS expectations switch on PC_GEN_RAS_EN.
module tb_pc_gen;
    localparam int XLEN = 32;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    pc_gen_if #(.XLEN(XLEN)) bus ();

    pc_gen #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic        stall, trap;
        logic [31:0] tvec;
        logic        flush;
        logic [31:0] fpc;
        logic        br;
        logic [31:0] bru;
        logic        call, ret;
        logic [31:0] exp_ras, exp_nr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        int          idx;
    } exp_t;

    localparam int NV = 35;
    vec_t vecs [NV];
    exp_t sbq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic s, logic t, logic [31:0] tv, logic f, logic [31:0] fp,
                                logic b, logic [31:0] bu, logic c, logic r,
                                logic [31:0] er, logic [31:0] en);
        vec_t v;
        v.stall = s; v.trap = t; v.tvec = tv; v.flush = f; v.fpc = fp;
        v.br = b; v.bru = bu; v.call = c; v.ret = r; v.exp_ras = er; v.exp_nr = en;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall_i    = v.stall;
        bus.trap_i     = v.trap;
        bus.trap_vec_i = v.tvec;
        bus.flush_i    = v.flush;
        bus.flush_pc_i = v.fpc;
        bus.br_sel_i   = v.br;
        bus.pc_bru_i   = v.bru;
        bus.call_i     = v.call;
        bus.ret_i      = v.ret;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        exp_t e;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0);
        //         st tr tvec          fl fpc           br bru           ca re ras           noras
        vecs[0]  = mk(0,0,0,            0,0,            0,0,            0,0,32'h0,        32'h0);
        vecs[1]  = mk(0,0,0,            0,0,            0,0,            0,0,32'h4,        32'h4);
        vecs[2]  = mk(0,0,0,            0,0,            0,0,            0,0,32'h8,        32'h8);
        vecs[3]  = mk(1,0,0,            0,0,            1,32'h100,      0,0,32'h8,        32'h8);
        vecs[4]  = mk(0,0,0,            0,0,            1,32'h100,      0,0,32'h100,      32'h100);
        vecs[5]  = mk(0,0,0,            0,0,            0,0,            1,0,32'h104,      32'h104);
        vecs[6]  = mk(1,1,32'h80,       1,32'h40,       0,0,            0,0,32'h80,       32'h80);
        vecs[7]  = mk(0,0,0,            0,0,            0,0,            0,1,32'h84,       32'h84);
        vecs[8]  = mk(1,0,0,            1,32'h10,       0,0,            0,0,32'h10,       32'h10);
        vecs[9]  = mk(0,0,0,            0,0,            1,32'h20,       1,0,32'h20,       32'h20);
        vecs[10] = mk(0,0,0,            0,0,            1,32'h30,       1,0,32'h30,       32'h30);
        vecs[11] = mk(0,0,0,            0,0,            1,32'h200,      1,0,32'h200,      32'h200);
        vecs[12] = mk(0,0,0,            0,0,            0,0,            0,1,32'h34,       32'h204);
        vecs[13] = mk(0,0,0,            0,0,            0,0,            0,1,32'h24,       32'h208);
        vecs[14] = mk(0,0,0,            1,32'h0,        0,0,            0,0,32'h0,        32'h0);
        vecs[15] = mk(0,0,0,            0,0,            0,0,            1,0,32'h4,        32'h4);
        vecs[16] = mk(0,0,0,            0,0,            0,0,            1,0,32'h8,        32'h8);
        vecs[17] = mk(0,0,0,            0,0,            0,0,            1,0,32'hC,        32'hC);
        vecs[18] = mk(0,0,0,            0,0,            0,0,            1,0,32'h10,       32'h10);
        vecs[19] = mk(0,0,0,            0,0,            0,0,            1,0,32'h14,       32'h14);
        vecs[20] = mk(0,0,0,            0,0,            0,0,            0,1,32'h14,       32'h18);
        vecs[21] = mk(0,0,0,            0,0,            0,0,            0,1,32'h10,       32'h1C);
        vecs[22] = mk(0,0,0,            0,0,            0,0,            0,1,32'hC,        32'h20);
        vecs[23] = mk(0,0,0,            0,0,            0,0,            0,1,32'h8,        32'h24);
        vecs[24] = mk(0,0,0,            0,0,            0,0,            0,1,32'hC,        32'h28);
        vecs[25] = mk(0,0,0,            1,32'h300,      0,0,            0,0,32'h300,      32'h300);
        vecs[26] = mk(0,0,0,            0,0,            0,0,            1,0,32'h304,      32'h304);
        vecs[27] = mk(0,0,0,            0,0,            0,0,            1,1,32'h304,      32'h308);
        vecs[28] = mk(0,0,0,            0,0,            0,0,            0,1,32'h308,      32'h30C);
        vecs[29] = mk(0,0,0,            1,32'h403,      0,0,            0,0,32'h400,      32'h400);
        vecs[30] = mk(0,1,32'h87,       0,0,            0,0,            0,0,32'h84,       32'h84);
        vecs[31] = mk(0,0,0,            1,32'hFFFFFFFF, 0,0,            0,0,32'hFFFFFFFC, 32'hFFFFFFFC);
        vecs[32] = mk(0,0,0,            0,0,            0,0,            0,0,32'h0,        32'h0);
        vecs[33] = mk(0,0,0,            0,0,            0,0,            0,0,32'h4,        32'h4);
        vecs[34] = mk(0,0,0,            0,0,            0,0,            0,0,32'h8,        32'h8);

        drive(idle);
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_pc", bus.pc_o, 32'h0);
        check("reset_valid", {31'b0, bus.pc_valid_o}, 32'h0);

        // Release between edges; the first edge afterwards is BOOT -> RUN.
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("boot_pc", bus.pc_o, 32'h0);
        check("boot_valid", {31'b0, bus.pc_valid_o}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            e.pc    = RAS_EN ? vecs[i].exp_ras : vecs[i].exp_nr;
            e.valid = 1'b1;
            e.idx   = i;
            sbq.push_back(e);
            @(posedge clk_i);
            #1;
            e = sbq.pop_front();
            check($sformatf("vec%0d_pc", e.idx), bus.pc_o, e.pc);
            check($sformatf("vec%0d_pc_four", e.idx), bus.pc_four_o, e.pc + 32'h4);
            check($sformatf("vec%0d_valid", e.idx), {31'b0, bus.pc_valid_o}, {31'b0, e.valid});
            @(negedge clk_i);
        end

        // Asynchronous reset mid-stream with a redirect pending.
        drive(mk(0,0,0,1,32'h500,0,0,0,0,0,0));
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_pc", bus.pc_o, 32'h0);
        check("async_rst_valid", {31'b0, bus.pc_valid_o}, 32'h0);
        @(posedge clk_i);
        #1;
        check("rst_hold_pc", bus.pc_o, 32'h0);
        @(negedge clk_i);
        drive(idle);
        rst_ni = 1'b1;
        #1;
        check("rerelease_valid", {31'b0, bus.pc_valid_o}, 32'h0);
        @(posedge clk_i);
        #1;
        check("rerun_pc0", bus.pc_o, 32'h0);
        check("rerun_valid", {31'b0, bus.pc_valid_o}, 32'h1);
        @(posedge clk_i);
        #1;
        check("rerun_pc1", bus.pc_o, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
